// File: rtl/pwm_duty_generator.sv
// PWM generator: high time per 2^PERIOD_BITS-cycle window equals the active duty.
// New duty values are double-buffered and applied only on period boundaries.
module pwm_duty_generator #(
    parameter int PERIOD_BITS = 8,
    parameter int DUTY_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DUTY_WIDTH-1:0] duty_in,
    input  logic                  duty_load,
    output logic                  duty_ack,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic [DUTY_WIDTH-1:0] active_duty,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int PADW = DUTY_WIDTH + 1 - PERIOD_BITS;
    localparam logic [PERIOD_BITS-1:0] LAST = '1;
    localparam logic [DUTY_WIDTH:0] FULL = (DUTY_WIDTH+1)'(1) << PERIOD_BITS;

    logic [1:0]             r_state;
    logic [PERIOD_BITS-1:0] r_cnt;
    logic [DUTY_WIDTH-1:0]  r_pend;
    logic                   r_pend_v;
    logic [DUTY_WIDTH-1:0]  r_active;
    logic                   r_pwm;
    logic                   r_start;
    logic                   r_ack;
    logic                   r_busy;

    logic [1:0]             w_state_n;
    logic [PERIOD_BITS-1:0] w_cnt_n;
    logic [DUTY_WIDTH-1:0]  w_pend_n;
    logic                   w_pend_v_n;
    logic [DUTY_WIDTH-1:0]  w_active_n;
    logic                   w_start_n;
    logic                   w_ack_n;
    logic                   w_last;
    logic [DUTY_WIDTH:0]    w_cnt_x;
    logic [DUTY_WIDTH:0]    w_act_x;
    logic [DUTY_WIDTH:0]    w_duty_eff;
    logic                   w_pwm_n;

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_pend_n   = r_pend;
        w_pend_v_n = r_pend_v;
        w_active_n = r_active;
        w_start_n  = 1'b0;
        w_ack_n    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (duty_load) begin
                    w_active_n = duty_in;
                    w_ack_n    = 1'b1;
                end
                if (enable) begin
                    w_state_n = S_RUN;
                    w_start_n = 1'b1;
                end
            end
            S_RUN, S_DRAIN: begin
                w_cnt_n = r_cnt + PERIOD_BITS'(1);
                if (enable)
                    w_state_n = S_RUN;
                else
                    w_state_n = w_last ? S_IDLE : S_DRAIN;
                // A same-cycle load at the boundary beats the held pending value
                if (w_last) begin
                    w_start_n  = enable;
                    w_pend_v_n = 1'b0;
                    if (duty_load || r_pend_v) begin
                        w_active_n = duty_load ? duty_in : r_pend;
                        w_ack_n    = 1'b1;
                    end
                end else if (duty_load) begin
                    w_pend_n   = duty_in;
                    w_pend_v_n = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign w_cnt_x    = {{PADW{1'b0}}, w_cnt_n};
    assign w_act_x    = {1'b0, w_active_n};
    assign w_duty_eff = (w_act_x > FULL) ? FULL : w_act_x;
    assign w_pwm_n    = (w_state_n != S_IDLE) && (w_cnt_x < w_duty_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_active <= '0;
            r_pwm    <= 1'b0;
            r_start  <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_pend   <= w_pend_n;
            r_pend_v <= w_pend_v_n;
            r_active <= w_active_n;
            r_pwm    <= w_pwm_n;
            r_start  <= w_start_n;
            r_ack    <= w_ack_n;
            r_busy   <= (w_state_n != S_IDLE);
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_start;
    assign duty_ack     = r_ack;
    assign active_duty  = r_active;
    assign busy         = r_busy;

endmodule

// File: doc/pwm_duty_generator.md
Name: pwm_duty_generator

Overview:
- Generates a PWM waveform whose high time per fixed window equals a programmed duty value.
- Duty encoding: number of high clock cycles per 2^PERIOD_BITS-cycle window, the same encoding the duty-cycle measurement path produces.
- A looped-back pwm_out measured over an aligned window therefore reads back the programmed value.
- New duty values are double-buffered and take effect only on period boundaries, so no period is ever glitched.

Parameters:
PERIOD_BITS, 8, window length is 2^PERIOD_BITS clock cycles (256 by default)
DUTY_WIDTH, 16, width of duty_in and active_duty

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  level; run request
duty_in  input  DUTY_WIDTH  requested duty, in high cycles per window
duty_load  input  1  one-cycle strobe; captures duty_in
duty_ack  output  1  one-cycle pulse when a loaded value becomes active
pwm_out  output  1  registered PWM output
period_start  output  1  high in cycle 0 of every output period
active_duty  output  DUTY_WIDTH  duty currently in force
busy  output  1  high in RUN and DRAIN

Behaviour:
- Reset (async assert): state=IDLE, counter=0, pending_valid=0, pending=0, active_duty=0. All outputs are 0 while reset is asserted and on release.
- Effective duty D = min(active_duty, 2^PERIOD_BITS). Comparison is unsigned at DUTY_WIDTH+1 bits; there is no wrap.
- D=0: pwm_out low all period. D>=2^PERIOD_BITS: pwm_out high all period.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: pwm_out=0, period_start=0, busy=0, counter held at 0. enable sampled 1 -> RUN. The first period starts in the next cycle (period_start=1 there).
  - RUN: counter steps 0..2^PERIOD_BITS-1 and wraps. Period cycle k is the cycle with counter=k; period_start=1 at k=0. pwm_out=1 for k<D, else 0, all registered and aligned to the same cycle.
    - enable sampled 0 in RUN -> DRAIN. The current period always completes.
  - DRAIN: identical output to RUN.
    - At the last cycle (k=2^PERIOD_BITS-1): enable=1 -> next period starts back-to-back (state RUN); enable=0 -> IDLE, pwm_out=0 next cycle.
    - enable returning to 1 mid-DRAIN -> RUN immediately, with no gap in the waveform.
- Duty handshake, RUN/DRAIN:
  - duty_load=1 writes duty_in into pending and sets pending_valid.
  - Repeated loads before a boundary overwrite pending (last wins); only one ack is issued.
  - At the last cycle of a period, any pending value, or duty_in if duty_load is asserted in that same cycle (which takes priority), becomes active_duty in the next period's cycle 0. duty_ack=1 and period_start=1 in that same cycle, and pending_valid clears.
  - A load at cycle 0 or later of period N takes effect at period N+1.
- Duty handshake, IDLE:
  - duty_load=1 updates active_duty in the next cycle and duty_ack=1 in that cycle.
  - A pending value left over from DRAIN is applied on entry to IDLE, with ack.
- enable=1 and duty_load=1 together in IDLE: the loaded value is in force for the first period (active_duty updated in the same cycle as the first period_start). duty_ack pulses once.
- active_duty never changes except at period cycle 0 or in IDLE.
- Reset mid-period: waveform terminates at once; pending and active values are lost. After release the block is in IDLE with active_duty=0.
- No combinational path from any input to any output.

Test Plan:
- Reset, then load duty_in=64 in IDLE, then raise enable.
  - duty_ack and active_duty=64 one cycle after the load.
  - First period_start one cycle after enable is sampled.
  - Exactly 64 high cycles at k=0..63, then 192 low; repeats every 256 cycles.
- Boundary extremes:
  - duty=0: pwm_out never high.
  - duty=256 and duty=1000: pwm_out constantly high across consecutive periods (saturation).
  - duty=255: a single low cycle at k=255.
- Update in RUN at duty 100:
  - Load 30 at k=50, then 200 at k=120 (last wins).
  - Next period: active_duty=200, 200 high cycles, one duty_ack coincident with period_start.
  - Current period keeps 100 high cycles.
- Load exactly at k=255 with pending=10 already held, duty_in=77: next period uses 77, single ack.
- Drop enable at k=10:
  - Period completes all 256 cycles, then pwm_out=0 and busy=0.
  - Variant: re-raise enable at k=200; next period starts back-to-back at k=0.
- Assert reset at k=30 of a duty-128 period: pwm_out, busy and active_duty drop to 0 immediately. After release, no output until enable is raised.
- Loopback: feed pwm_out into the duty-cycle measurement path with an aligned 256-cycle window. For duty values 0, 1, 128, 255 the readback equals the programmed value.
